// File: rtl/imx_sync_pattern_gen.sv
// Multi-lane Sony IMX sensor timing generator: vsync/hsync plus per-lane bytes carrying
// the 7F/80/00/40 row header followed by a selectable payload pattern.
module imx_sync_pattern_gen #(
    parameter int LANE_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_enable,
    input  logic                    i_free_run,
    input  logic                    i_trigger,
    input  logic [1:0]              i_pattern,
    input  logic [CNT_WIDTH-1:0]    i_vs_low,
    input  logic [CNT_WIDTH-1:0]    i_rows,
    input  logic [CNT_WIDTH-1:0]    i_hs_low,
    input  logic [CNT_WIDTH-1:0]    i_row_len,
    input  logic [CNT_WIDTH-1:0]    i_row_delay,
    output logic                    o_vs,
    output logic                    o_hs,
    output logic [8*LANE_WIDTH-1:0] o_data,
    output logic                    o_busy,
    output logic                    o_frame_start,
    output logic                    o_frame_done,
    output logic                    o_trig_overrun,
    output logic [CNT_WIDTH-1:0]    o_row_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_VBLANK,
        ST_HBLANK,
        ST_ROW
    } state_e;

    typedef struct packed {
        logic [CNT_WIDTH-1:0] vs_low;
        logic [CNT_WIDTH-1:0] rows;
        logic [CNT_WIDTH-1:0] hs_low;
        logic [CNT_WIDTH-1:0] row_len;
        logic [CNT_WIDTH-1:0] row_delay;
        logic [1:0]           pattern;
    } cfg_t;

    localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH:0]   HDR_BEATS = (CNT_WIDTH+1)'(4);

    function automatic logic [CNT_WIDTH-1:0] at_least_one(input logic [CNT_WIDTH-1:0] v);
        return (v == '0) ? ONE : v;
    endfunction

    function automatic logic [7:0] header_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h7F;
            2'd1:    return 8'h80;
            2'd2:    return 8'h00;
            default: return 8'h40;
        endcase
    endfunction

    state_e                  state_q, state_d;
    cfg_t                    cfg_q, cfg_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]    row_cnt_q, row_cnt_d;
    logic                    vs_q, vs_d;
    logic                    hs_q, hs_d;
    logic                    busy_q, busy_d;
    logic                    start_q, start_d;
    logic                    done_q, done_d;
    logic                    overrun_q, overrun_d;
    logic [8*LANE_WIDTH-1:0] data_q, data_d;

    // Row-phase decode of the cycle about to be presented on the outputs.
    logic [CNT_WIDTH:0]      c_ext, hdr_start, pay_start;
    logic [1:0]              hdr_idx;
    logic [7:0]              beat_byte;
    logic [7:0]              common_byte;
    logic                    in_payload;

    // NOTE: every variable driven here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        cnt_d     = cnt_q;
        row_cnt_d = row_cnt_q;
        start_d   = 1'b0;
        done_d    = 1'b0;
        overrun_d = i_trigger && busy_q;

        case (state_q)
            ST_IDLE: begin
                if (i_enable && (i_free_run || i_trigger)) begin
                    state_d = ST_VBLANK;
                end
            end
            ST_VBLANK: begin
                if (cnt_q == cfg_q.vs_low - ONE) begin
                    state_d = ST_HBLANK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            ST_HBLANK: begin
                if (cnt_q == cfg_q.hs_low - ONE) begin
                    state_d = ST_ROW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            ST_ROW: begin
                if (cnt_q == cfg_q.row_len - ONE) begin
                    cnt_d     = '0;
                    row_cnt_d = row_cnt_q + ONE;
                    if (row_cnt_q == cfg_q.rows - ONE) begin
                        done_d  = 1'b1;
                        state_d = (i_enable && i_free_run) ? ST_VBLANK : ST_IDLE;
                    end else begin
                        state_d = ST_HBLANK;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Any entry into VBLANK starts a new frame and snapshots the configuration.
        if (state_d == ST_VBLANK && state_q != ST_VBLANK) begin
            cnt_d             = '0;
            row_cnt_d         = '0;
            start_d           = 1'b1;
            cfg_d.vs_low      = at_least_one(i_vs_low);
            cfg_d.rows        = at_least_one(i_rows);
            cfg_d.hs_low      = at_least_one(i_hs_low);
            cfg_d.row_len     = at_least_one(i_row_len);
            cfg_d.row_delay   = i_row_delay;
            cfg_d.pattern     = i_pattern;
        end

        vs_d   = (state_d == ST_HBLANK) || (state_d == ST_ROW);
        hs_d   = (state_d == ST_ROW);
        busy_d = (state_d != ST_IDLE);
    end

    // Widened by one bit so row_delay near full scale cannot wrap the header window.
    always_comb begin
        c_ext       = {1'b0, cnt_d};
        hdr_start   = {1'b0, cfg_d.row_delay};
        pay_start   = hdr_start + HDR_BEATS;
        hdr_idx     = cnt_d[1:0] - cfg_d.row_delay[1:0];
        beat_byte   = c_ext[7:0] - pay_start[7:0];
        in_payload  = 1'b0;
        common_byte = 8'h00;

        if (c_ext < hdr_start) begin
            common_byte = 8'h00;
        end else if (c_ext < pay_start) begin
            common_byte = header_byte(hdr_idx);
        end else begin
            in_payload = 1'b1;
            case (cfg_d.pattern)
                2'd1:    common_byte = beat_byte;
                2'd3:    common_byte = row_cnt_d[7:0];
                default: common_byte = 8'h00;
            endcase
        end

        data_d = '0;
        if (state_d == ST_ROW) begin
            for (int k = 0; k < LANE_WIDTH; k++) begin
                data_d[8*k +: 8] = (in_payload && cfg_d.pattern == 2'd2) ? 8'(k) : common_byte;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            // NOTE: the config snapshot is reset too, keeping post-reset behaviour fully deterministic.
            state_q   <= ST_IDLE;
            cfg_q     <= '0;
            cnt_q     <= '0;
            row_cnt_q <= '0;
            vs_q      <= 1'b0;
            hs_q      <= 1'b0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            cnt_q     <= cnt_d;
            row_cnt_q <= row_cnt_d;
            vs_q      <= vs_d;
            hs_q      <= hs_d;
            busy_q    <= busy_d;
            start_q   <= start_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            data_q    <= data_d;
        end
    end

    assign o_vs           = vs_q;
    assign o_hs           = hs_q;
    assign o_data         = data_q;
    assign o_busy         = busy_q;
    assign o_frame_start  = start_q;
    assign o_frame_done   = done_q;
    assign o_trig_overrun = overrun_q;
    assign o_row_count    = row_cnt_q;

endmodule
